// File: rtl/ray_frame_scheduler.sv
// Frame sequencer for primary rays: walks pixels in raster order and hands them
// to NUM_UNITS trace units with round-robin arbitration and per-unit credits.
module ray_frame_scheduler #(
    parameter int NUM_UNITS = 4,
    parameter int CREDITS   = 2,
    parameter int DIM_W     = 13
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DIM_W-1:0]       image_width,
    input  logic [DIM_W-1:0]       image_height,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_error,
    output logic                   proto_error,
    output logic [NUM_UNITS-1:0]   dispatch_valid,
    input  logic [NUM_UNITS-1:0]   unit_ready,
    output logic [DIM_W-1:0]       pixel_x,
    output logic [DIM_W-1:0]       pixel_y,
    output logic [2*DIM_W-1:0]     pixel_index,
    input  logic [NUM_UNITS-1:0]   done_valid
);

    localparam int PTR_W = $clog2(NUM_UNITS);
    localparam int IDX_W = 2 * DIM_W;
    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    typedef enum logic [1:0] {IDLE, LOAD, DISPATCH, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [DIM_W-1:0]            w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic [IDX_W-1:0]            total_q, total_d, index_q, index_d;
    logic [NUM_UNITS-1:0]        valid_q, valid_d;
    logic [PTR_W-1:0]            gnt_q, gnt_d, rr_q, rr_d;
    logic [NUM_UNITS-1:0][2:0]   credit_q, credit_d;
    logic                        done_q, done_d, cfg_err_q, cfg_err_d, proto_q, proto_d;
    logic                        xfer, found;
    logic [PTR_W-1:0]            cand, pick;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        total_d   = total_q;
        x_d       = x_q;
        y_d       = y_q;
        index_d   = index_q;
        valid_d   = valid_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        credit_d  = credit_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        proto_d   = proto_q;
        xfer      = |(valid_q & unit_ready);
        found     = 1'b0;
        cand      = '0;
        pick      = rr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (image_width != '0 && image_height != '0) begin
                        w_d     = image_width;
                        h_d     = image_height;
                        total_d = IDX_W'(image_width) * IDX_W'(image_height);
                        proto_d = 1'b0;
                        state_d = LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                x_d     = '0;
                y_d     = '0;
                index_d = '0;
                state_d = DISPATCH;
            end
            DISPATCH: begin
                if (xfer) begin
                    rr_d    = gnt_q + PTR_W'(1);
                    index_d = index_q + IDX_W'(1);
                    valid_d = '0;
                    if (x_q == w_q - DIM_W'(1)) begin
                        x_d = '0;
                        y_d = y_q + DIM_W'(1);
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                    if (index_q == total_q - IDX_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credit_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer and a completion on the same unit cancel out.
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (xfer && gnt_q == PTR_W'(i)) begin
                credit_d[i] = credit_d[i] + 3'd1;
            end
            if (done_valid[i]) begin
                if (credit_q[i] != 3'd0 && state_q != IDLE) begin
                    credit_d[i] = credit_d[i] - 3'd1;
                end else begin
                    proto_d = 1'b1;
                end
            end
        end

        // Arbitrate against next-cycle credits so a freed slot is usable at once.
        if (state_q == DISPATCH && state_d == DISPATCH && valid_d == '0) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                cand = rr_d + PTR_W'(k);
                if (!found && credit_d[cand] < CRED_MAX) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
            if (found) begin
                valid_d = NUM_UNITS'(1) << pick;
                gnt_d   = pick;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            total_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            index_q   <= '0;
            valid_q   <= '0;
            gnt_q     <= '0;
            rr_q      <= '0;
            credit_q  <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            total_q   <= total_d;
            x_q       <= x_d;
            y_q       <= y_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            credit_q  <= credit_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            proto_q   <= proto_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign frame_done     = done_q;
    assign cfg_error      = cfg_err_q;
    assign proto_error    = proto_q;
    assign dispatch_valid = valid_q;
    assign pixel_x        = x_q;
    assign pixel_y        = y_q;
    assign pixel_index    = index_q;

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
- Sequences one frame of primary-ray work: sweeps pixel coordinates in raster order and dispatches them to NUM_UNITS parallel ray-generation/trace units.
- Round-robin arbitration among units; per-unit credit limit.
- Counts completions and pulses frame_done when every pixel has been issued and returned.
- Sits between the host/camera configuration registers and the ray-generation pipelines.

Parameters:
- NUM_UNITS, 4, number of downstream units (power of 2, 2..8).
- CREDITS, 2, maximum outstanding pixels per unit (1..7).
- DIM_W, 13, width of image dimensions and pixel coordinates.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame start request; sampled only in IDLE.
- image_width  in  DIM_W  pixels per row; latched on accepted start.
- image_height  in  DIM_W  rows per frame; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.
- cfg_error  out  1  one-cycle pulse when start is rejected for a zero dimension.
- proto_error  out  1  sticky; cleared on accepted start.
- dispatch_valid  out  NUM_UNITS  one-hot (or zero) offer to a unit.
- unit_ready  in  NUM_UNITS  per-unit accept.
- pixel_x  out  DIM_W  column of offered pixel.
- pixel_y  out  DIM_W  row of offered pixel.
- pixel_index  out  2*DIM_W  linear index y*W+x.
- done_valid  in  NUM_UNITS  per-unit completion pulse; one pixel each.

Behaviour:
Reset values:
- All outputs 0; state IDLE; all counters and credits 0; round-robin pointer 0.
- Reset mid-frame aborts immediately; no frame_done is issued.

States: IDLE, LOAD, DISPATCH, DRAIN.
- IDLE, start=1, W≠0 and H≠0: latch W and H; total = W*H (2*DIM_W bits); clear proto_error; go to LOAD.
- IDLE, start=1, W=0 or H=0: pulse cfg_error next cycle; stay IDLE.
- start in any other state: ignored.
- LOAD: x=y=index=issued=0; go to DISPATCH. busy=1 from this cycle on.

DISPATCH:
- A unit is eligible when credit[i] < CREDITS.
- When no offer is pending, select the first eligible unit at or after rr_ptr (circular search). Assert its dispatch_valid bit with the current x, y and index on the next clock edge.
- First offer appears 2 cycles after the start sample: start sampled at edge T, LOAD at T+1, valid at T+2.
- An offer, once made, holds dispatch_valid and payload stable until unit_ready of that unit is high. No retargeting.
- Transfer = dispatch_valid[i] && unit_ready[i]. On transfer:
  - credit[i]++, issued++, rr_ptr=i+1 mod NUM_UNITS.
  - Advance coordinates: x++; when x reaches W-1, x=0 and y++; index++.
- A new offer may be presented the cycle after a transfer. Sustained throughput is 1 pixel/cycle when units are ready and credited.
- After the transfer of index total-1: deassert valid; go to DRAIN.

Completions, in any state:
- done_valid[i] with credit[i]>0: credit[i]--.
- Simultaneous transfer to unit i and done_valid[i]: credit unchanged.
- done_valid[i] with credit[i]=0, or any done_valid in IDLE: ignored and sets proto_error.
- Multiple done_valid bits in one cycle are all processed.

DRAIN:
- When all credits are 0, pulse frame_done for one cycle, drop busy in the same cycle, and go to IDLE.
- The earliest frame_done is one cycle after the last credit clears.

Pixel order: row-major, y=0 first; index equals y*W+x, maintained by an incrementer rather than a multiplier.
Widths: issued and index counters are 2*DIM_W bits. W=H=2^DIM_W-1 must not overflow.

Test Plan:
- W=4, H=2, all unit_ready=1, done_valid echoed 3 cycles after each transfer -> 8 transfers; units granted 0,1,2,3,0,1,2,3; (x,y) from (0,0) to (3,1); index 0..7; exactly one frame_done; busy high throughout.
- W=3, H=1, unit_ready[0]=0 for 5 cycles while unit 0 is offered -> payload (0,0,0) held stable on dispatch_valid=0001 for 5 cycles; no other unit offered; completes normally.
- CREDITS=2, NUM_UNITS=2, no done_valid for 10 cycles, W=8, H=1 -> exactly 4 transfers then valid stays 0. Releasing done pulses resumes dispatch; frame_done only after all 8 return.
- start with W=0, H=5 -> cfg_error pulse, busy stays 0, no dispatch. done_valid=0100 while idle -> proto_error=1 until next accepted start.
- reset_n low mid-DISPATCH after 3 transfers -> all outputs 0 asynchronously. New start with W=H=1 -> single pixel (0,0) dispatched to unit 0, frame_done after its completion.
- Same-cycle transfer and done_valid on unit 1 with credit[1]=1 -> credit[1] stays 1; start asserted during DRAIN is ignored.
